// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the core pipeline sequencer: stall vector encodings,
// the eret exception code, FSM state encodings and the legacy word defines.
// No logic; imported by the interface, the watchdog and the top.
package pipe_ctrl_pkg;

    // Legacy defines kept so existing pipeline-register code reads the same.
    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef logic [5:0] stall_t;   // [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb

    // A stalling stage freezes itself and everything upstream of it.
    localparam stall_t STALL_NONE = 6'b000000;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_MEM  = 6'b011111;   // wb keeps running and receives a bubble

    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_GAP = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline sequencer and the six pipeline stages.
// master: sequencer side (consumes stall requests and the exception, drives control).
// slave : pipeline side (drives requests and the exception, consumes control).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    stall_t      stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdog_timeout;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem, excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, wdog_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem, excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, wdog_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky timeout.
// Latency: timeout sets on the edge ending the WDOG_LIMIT-th consecutive stalled cycle.
// Backpressure: none; observes stall/flush only.
// Ports: clk, rst (async, active-low), stalled, flush in; timeout out (sticky until flush/reset).
module stall_wdog #(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    input  logic flush,
    output logic timeout
);

    localparam logic [15:0] LIMIT    = 16'(WDOG_LIMIT);
    localparam logic [15:0] LIMIT_M1 = 16'(WDOG_LIMIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 16'd0;
            timeout <= 1'b0;
        end else begin
            // Any idle or flush cycle breaks the consecutive run; saturate rather than wrap.
            if (flush || !stalled)
                cnt <= 16'd0;
            else if (cnt != LIMIT)
                cnt <= cnt + 16'd1;

            if (flush)
                timeout <= 1'b0;
            else if (stalled && (cnt >= LIMIT_M1))
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, sequences exception/eret flushes, runs a stall watchdog.
// Latency: stall/flush/new_pc are combinational (zero cycles); state, watchdog and counters update on the edge.
// Backpressure: stall requests are the backpressure; a taken exception overrides them (stall forced to 0).
// Ports: clk, rst (async, active-low), bus (pipe_ctrl_if.master: requests, excepttype_i, cp0_epc_i in;
//        stall, flush, new_pc, wdog_timeout, stall_cnt, flush_cnt out).
// Optional: define PIPE_CTRL_PERF_EN for stall_cnt/flush_cnt counters; otherwise both read as 0.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          WDOG_LIMIT = 1024,
    parameter int          FLUSH_GAP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.master   bus
);

    logic [0:0] state;
    logic [2:0] gap_cnt;
    stall_t     stall_req;
    logic       take;

    always_comb begin
        stall_req = STALL_NONE;
        if (bus.stallreq_from_mem)
            stall_req = STALL_MEM;
        else if (bus.stallreq_from_ex)
            stall_req = STALL_EX;
        else if (bus.stallreq_from_id)
            stall_req = STALL_ID;
    end

    // Exceptions arriving during the post-flush gap are stale copies of the one already taken.
    assign take = (state == ST_RUN) && (bus.excepttype_i != ZeroWord);

    assign bus.flush  = take;
    assign bus.stall  = take ? STALL_NONE : stall_req;
    assign bus.new_pc = !take                          ? ZeroWord      :
                        (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            gap_cnt <= 3'd0;
        end else if (take) begin
            state   <= ST_GAP;
            gap_cnt <= 3'(FLUSH_GAP - 1);
        end else if (state == ST_GAP) begin
            if (gap_cnt == 3'd0)
                state <= ST_RUN;
            else
                gap_cnt <= gap_cnt - 3'd1;
        end
    end

    stall_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .stalled (bus.stall != STALL_NONE),
        .flush   (take),
        .timeout (bus.wdog_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (bus.stall != STALL_NONE)
                stall_cnt_q <= stall_cnt_q + 32'd1;     // wraps
            if (take && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;     // saturates
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
    assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed steps followed by random traffic, each cycle compared
// against a cycle-level reference model built from the stall priority table, an ignore-window
// counter for post-flush cycles and a consecutive-stall run length for the watchdog.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h0000_0020;
    localparam int          WDOG    = 8;
    localparam int          GAP     = 1;

    logic clk;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .EXC_VECTOR (EXC_VEC),
        .WDOG_LIMIT (WDOG),
        .FLUSH_GAP  (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_ignore;     // cycles left in which exceptions are ignored
    int          m_run;        // consecutive stalled cycles so far
    logic        m_wdog;
    logic [31:0] m_stall_cnt;
    logic [15:0] m_flush_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] prio(input logic id, input logic ex, input logic mem);
        if (mem) return 6'b011111;
        if (ex)  return 6'b001111;
        if (id)  return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic [31:0] exp_scnt();
`ifdef PIPE_CTRL_PERF_EN
        return m_stall_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_fcnt();
`ifdef PIPE_CTRL_PERF_EN
        return m_flush_cnt;
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        m_ignore    = 0;
        m_run       = 0;
        m_wdog      = 1'b0;
        m_stall_cnt = 32'd0;
        m_flush_cnt = 16'd0;
    endtask

    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic [31:0] exc, input logic [31:0] epc);
        bus.stallreq_from_id  = id;
        bus.stallreq_from_ex  = ex;
        bus.stallreq_from_mem = mem;
        bus.excepttype_i      = exc;
        bus.cp0_epc_i         = epc;
    endtask

    // One clock cycle: drive after the falling edge, check before the rising edge,
    // advance the model with what the rising edge commits, return at the next falling edge.
    task automatic cyc(input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
        logic        take;
        logic [5:0]  e_stall;
        logic [31:0] e_pc;
        drive(id, ex, mem, exc, epc);
        #1;
        take    = (m_ignore == 0) && (exc != 32'd0);
        e_stall = take ? 6'd0 : prio(id, ex, mem);
        e_pc    = !take ? 32'd0 : (exc == 32'h0000_000e) ? epc : EXC_VEC;
        check("stall",     {26'd0, bus.stall},     {26'd0, e_stall});
        check("flush",     {31'd0, bus.flush},     {31'd0, take});
        check("new_pc",    bus.new_pc,             e_pc);
        check("wdog",      {31'd0, bus.wdog_timeout}, {31'd0, m_wdog});
        check("stall_cnt", bus.stall_cnt,          exp_scnt());
        check("flush_cnt", {16'd0, bus.flush_cnt}, {16'd0, exp_fcnt()});
        @(posedge clk);
        if (take) begin
            m_ignore = GAP;
            m_run    = 0;
            m_wdog   = 1'b0;
            if (m_flush_cnt != 16'hFFFF) m_flush_cnt++;
        end else begin
            if (m_ignore > 0) m_ignore--;
            if (e_stall != 6'd0) begin
                m_run++;
                if (m_run >= WDOG) m_wdog = 1'b1;
                m_stall_cnt++;
            end else begin
                m_run = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        logic        r_id, r_ex, r_mem;
        logic [31:0] r_exc, r_epc;

        // ---- reset state ----
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",  {26'd0, bus.stall}, 32'd0);
        check("rst_flush",  {31'd0, bus.flush}, 32'd0);
        check("rst_new_pc", bus.new_pc,         32'd0);
        check("rst_wdog",   {31'd0, bus.wdog_timeout}, 32'd0);
        check("rst_scnt",   bus.stall_cnt,      32'd0);
        check("rst_fcnt",   {16'd0, bus.flush_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- ex stall for exactly 3 cycles ----
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("ex3_wdog", {31'd0, bus.wdog_timeout}, 32'd0);

        // ---- priority: mem > ex > id ----
        cyc(1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---- exception over mem stall, held through GAP, retaken ----
        drive(1'b0, 1'b0, 1'b1, 32'h1, 32'd0);
        #1;
        check("exc_flush",  {31'd0, bus.flush}, 32'd1);
        check("exc_stall",  {26'd0, bus.stall}, 32'd0);
        check("exc_new_pc", bus.new_pc, 32'h0000_0020);
        @(negedge clk);
        m_ignore = 0;  // model not yet advanced for this cycle; redo it through cyc
        // Re-enter via cyc from a clean falling edge: the cycle above already committed a take,
        // so rebuild the model for that edge before continuing.
        m_ignore = GAP; m_run = 0; m_wdog = 1'b0; m_flush_cnt++;
        cyc(1'b0, 1'b0, 1'b1, 32'h1, 32'd0);            // GAP: ignored, stall passes through
        cyc(1'b0, 1'b0, 1'b1, 32'h1, 32'd0);            // flush again
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---- eret ----
        drive(1'b0, 1'b0, 1'b0, 32'h0000_000e, 32'h0000_1234);
        #1;
        check("eret_new_pc", bus.new_pc, 32'h0000_1234);
        @(negedge clk);
        m_ignore = GAP; m_run = 0; m_wdog = 1'b0; m_flush_cnt++;
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---- watchdog with WDOG_LIMIT=8 ----
        repeat (7) cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("wdog_pre", {31'd0, bus.wdog_timeout}, 32'd0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("wdog_sticky", {31'd0, bus.wdog_timeout}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 32'h4, 32'd0);
        check("wdog_clr", {31'd0, bus.wdog_timeout}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // ---- perf counters: 5 stalls + 2 flushes from a fresh reset ----
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h8, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h8, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
`ifdef PIPE_CTRL_PERF_EN
        check("perf_scnt", bus.stall_cnt, 32'd5);
        check("perf_fcnt", {16'd0, bus.flush_cnt}, 32'd2);
`else
        check("perf_scnt", bus.stall_cnt, 32'd0);
        check("perf_fcnt", {16'd0, bus.flush_cnt}, 32'd0);
`endif

        // ---- async reset mid-GAP, between clock edges ----
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 32'h2, 32'd0);            // take; now in GAP
        drive(1'b0, 1'b0, 1'b1, 32'h2, 32'd0);
        #1;
        check("gap_flush", {31'd0, bus.flush}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check("arst_flush", {31'd0, bus.flush}, 32'd1);   // state back to RUN without an edge
        check("arst_scnt",  bus.stall_cnt, 32'd0);
        check("arst_fcnt",  {16'd0, bus.flush_cnt}, 32'd0);
        check("arst_wdog",  {31'd0, bus.wdog_timeout}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // ---- random traffic ----
        for (int i = 0; i < 400; i++) begin
            r_id  = ($urandom_range(0, 3) != 0);
            r_ex  = ($urandom_range(0, 5) == 0);
            r_mem = ($urandom_range(0, 7) == 0);
            r_epc = $urandom;
            r_exc = 32'd0;
            if ($urandom_range(0, 9) == 0)
                r_exc = ($urandom_range(0, 1) == 1) ? 32'h0000_000e : $urandom;
            cyc(r_id, r_ex, r_mem, r_exc, r_epc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
- Merges stage stall requests into the per-stage stall[5:0] vector that every pipeline register (if_id … mem_wb) consumes.
- Sequences exception/eret flushes and supplies the redirect PC.
- Runs a stall watchdog and optional stall performance counters.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for all non-eret exceptions.
- WDOG_LIMIT, 1024, consecutive stalled cycles before wdog_timeout asserts; legal range 2..65535.
- FLUSH_GAP, 1, cycles after a flush during which new exceptions are ignored; legal range 1..7.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- stallreq_from_id  in  1  id stage operand hazard
- stallreq_from_ex  in  1  ex multi-cycle op (div/madd)
- stallreq_from_mem  in  1  mem stage bus wait
- excepttype_i  in  32  final exception type from mem stage; 0 = none
- cp0_epc_i  in  32  current EPC (forwarded)
- stall  out  6  stall[0]=pc … stall[5]=wb; 1 = Stop
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush=1
- wdog_timeout  out  1  sticky stall watchdog flag
- stall_cnt  out  32  total stalled cycles (PIPE_CTRL_PERF_EN only)
- flush_cnt  out  16  flushes taken (PIPE_CTRL_PERF_EN only)

Behaviour:
- Reset (rst=0, async): state=RUN, gap counter=0, watchdog counter=0, wdog_timeout=0, perf counters=0. Outputs: stall=0, flush=0, new_pc=0.
- stall is combinational from the requests, with zero latency, because pipeline registers sample it in the same cycle.
- Stall priority: mem > ex > id.
  - mem → 6'b011111 (wb gets a bubble).
  - ex → 6'b001111.
  - id → 6'b000111.
  - none → 0.
- Exception take: condition is state=RUN and excepttype_i!=0.
  - flush=1 combinationally that cycle, and stall is forced to 0.
  - new_pc = cp0_epc_i if excepttype_i==32'h0000000e (eret), else EXC_VECTOR.
  - On the next edge: state→GAP and gap counter loads FLUSH_GAP-1.
  - Exception takes precedence over any simultaneous stall request.
- GAP:
  - flush=0 and excepttype_i is ignored.
  - stall is generated normally.
  - The counter decrements each cycle; at 0, state→RUN on the next edge.
  - With FLUSH_GAP=1, exactly one ignored cycle follows each flush.
- new_pc holds 0 whenever flush=0.
- Watchdog counter (16 bits):
  - Increments each cycle stall!=0.
  - Clears on any cycle with stall==0 or flush=1.
  - Saturates at WDOG_LIMIT; does not wrap.
  - When the count reaches WDOG_LIMIT-1 while still stalled, wdog_timeout sets on that edge.
  - wdog_timeout clears only on reset or flush.
- Reset asserted mid-stall or mid-GAP aborts everything immediately; the first cycle after release is RUN.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments each cycle stall!=0 and wraps at 2^32.
  - flush_cnt increments on each exception take and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined:
  - Both ports are tied to 0.
  - No counter flops are synthesised.

Decomposition:
- Shared defines file gets:
  - the stall vector encodings STALL_NONE/ID/EX/MEM;
  - the eret exception code;
  - state encodings RUN/GAP.
- Reuse the existing Stop/NoStop/ZeroWord defines.
- One sub-module: stall_wdog (counter + sticky flag, parameterised by WDOG_LIMIT).

Test Plan:
- Reset release; drive stallreq_from_ex=1 for 3 cycles, then 0 → stall=6'b001111 in exactly those 3 cycles, then 0; wdog_timeout=0.
- Set id, ex and mem requests in the same cycle → stall=6'b011111. Drop mem → 6'b001111. Drop ex → 6'b000111.
- excepttype_i=32'h00000001 with stallreq_from_mem=1 → same cycle flush=1, stall=0, new_pc=32'h00000020.
  - Hold excepttype_i for the next cycle → flush=0 (GAP).
  - Third cycle → flush=1 again.
- excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234 → flush=1, new_pc=32'h00001234.
- WDOG_LIMIT=8; hold stallreq_from_id → wdog_timeout rises after the 8th stalled cycle and stays high after the stall drops. Then take an exception → wdog_timeout clears.
- PIPE_CTRL_PERF_EN defined; 5 stalled cycles plus 2 flushes → stall_cnt=5, flush_cnt=2.
  - Assert rst=0 asynchronously between clock edges → both counters and state clear before the next edge.
